// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipelined CPU control path: opcodes,
// field encodings and the decode-stage control bundle.
package cpu_pkg;

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_XOR    = 4'h2;
  localparam logic [3:0] OP_RED    = 4'h3;
  localparam logic [3:0] OP_SLL    = 4'h4;
  localparam logic [3:0] OP_SRA    = 4'h5;
  localparam logic [3:0] OP_ROR    = 4'h6;
  localparam logic [3:0] OP_PADDSB = 4'h7;
  localparam logic [3:0] OP_LW     = 4'h8;
  localparam logic [3:0] OP_SW     = 4'h9;
  localparam logic [3:0] OP_LLB    = 4'hA;
  localparam logic [3:0] OP_LHB    = 4'hB;
  localparam logic [3:0] OP_B      = 4'hC;
  localparam logic [3:0] OP_BR     = 4'hD;
  localparam logic [3:0] OP_PCS    = 4'hE;
  localparam logic [3:0] OP_HLT    = 4'hF;

  localparam logic [1:0] MTR_PC2 = 2'b00;
  localparam logic [1:0] MTR_IMM = 2'b01;
  localparam logic [1:0] MTR_ALU = 2'b10;
  localparam logic [1:0] MTR_MEM = 2'b11;

  localparam logic [1:0] PCS_SEQ = 2'b00;
  localparam logic [1:0] PCS_BR  = 2'b01;
  localparam logic [1:0] PCS_B   = 2'b11;

  // flag write enables are ordered {Z,V,N}
  localparam logic [2:0] FLAG_NONE = 3'b000;
  localparam logic [2:0] FLAG_Z    = 3'b100;
  localparam logic [2:0] FLAG_ALL  = 3'b111;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic       lhb;
    logic [2:0] alu_op;
    logic [1:0] mem_to_reg;
    logic [1:0] pc_src;
    logic [2:0] flag_we;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_DRAIN  = 2'b01,
    ST_HALTED = 2'b10
  } halt_state_e;

  function automatic logic reg_hit(input logic [3:0] ex_rd, input logic [3:0] src,
                                   input logic used);
    return used && (ex_rd == src);
  endfunction

endpackage

// File: rtl/pipe_ctrl_unit_if.sv
// Decode-stage control bus: IF/ID inputs, hazard enables and the ID/EX
// control slice. slave = control unit side, master = pipeline side.
interface pipe_ctrl_unit_if #(
  parameter int INSTR_W = 16,
  parameter int RIDX_W  = 4
);
  logic               id_valid;
  logic [INSTR_W-1:0] id_instr;
  logic               ex_branch_taken;
  logic               pc_write;
  logic               if_id_write;
  logic               if_id_flush;
  logic               ex_valid;
  logic               ex_reg_write;
  logic               ex_mem_read;
  logic               ex_mem_write;
  logic               ex_alu_src;
  logic               ex_lhb;
  logic [2:0]         ex_alu_op;
  logic [1:0]         ex_mem_to_reg;
  logic [1:0]         ex_pc_src;
  logic [2:0]         ex_flag_we;
  logic [RIDX_W-1:0]  ex_rd;
  logic               halted;

  modport master (
    output id_valid, id_instr, ex_branch_taken,
    input  pc_write, if_id_write, if_id_flush, ex_valid, ex_reg_write, ex_mem_read,
           ex_mem_write, ex_alu_src, ex_lhb, ex_alu_op, ex_mem_to_reg, ex_pc_src,
           ex_flag_we, ex_rd, halted
  );

  modport slave (
    input  id_valid, id_instr, ex_branch_taken,
    output pc_write, if_id_write, if_id_flush, ex_valid, ex_reg_write, ex_mem_read,
           ex_mem_write, ex_alu_src, ex_lhb, ex_alu_op, ex_mem_to_reg, ex_pc_src,
           ex_flag_we, ex_rd, halted
  );
endinterface

// File: rtl/ctrl_decode.sv
// Purely combinational opcode decoder: control bundle plus register-read
// classification used by the load-use hazard check.
module ctrl_decode
  import cpu_pkg::*;
#(
  parameter int OP_W = 4
) (
  input  logic [OP_W-1:0] opcode,
  output ctrl_t           ctrl,
  output logic            uses_rs,
  output logic            uses_rt,
  output logic            uses_rd_src
);

  // opcode -> control bundle
  always_comb begin
    ctrl = CTRL_BUBBLE;
    case (opcode)
      OP_ADD, OP_SUB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_op     = opcode[2:0];
        ctrl.mem_to_reg = MTR_ALU;
        ctrl.flag_we    = FLAG_ALL;
      end
      OP_XOR, OP_RED, OP_PADDSB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_op     = opcode[2:0];
        ctrl.mem_to_reg = MTR_ALU;
        ctrl.flag_we    = FLAG_Z;
      end
      OP_SLL, OP_SRA, OP_ROR: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.alu_op     = opcode[2:0];
        ctrl.mem_to_reg = MTR_ALU;
        ctrl.flag_we    = FLAG_Z;
      end
      OP_LW: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.mem_to_reg = MTR_MEM;
      end
      OP_SW: begin
        ctrl.mem_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.mem_to_reg = MTR_ALU;
      end
      OP_LLB, OP_LHB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.alu_op     = 3'b010;
        ctrl.mem_to_reg = MTR_IMM;
        ctrl.lhb        = (opcode == OP_LHB);
      end
      OP_B: begin
        ctrl.alu_src = 1'b1;
        ctrl.pc_src  = PCS_B;
      end
      OP_BR: begin
        ctrl.pc_src = PCS_BR;
      end
      OP_PCS: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.mem_to_reg = MTR_PC2;
      end
      default: ctrl = CTRL_BUBBLE;
    endcase
  end

  assign uses_rs     = (opcode <= OP_SW) || (opcode == OP_BR);
  assign uses_rt     = (opcode <= OP_RED) || (opcode == OP_PADDSB);
  assign uses_rd_src = (opcode == OP_SW);

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Decode-stage control unit: registers the decoded bundle into ID/EX, inserts
// load-use stalls, applies EX branch flushes and drains the pipe on HLT.
module pipe_ctrl_unit
  import cpu_pkg::*;
#(
  parameter int INSTR_W      = 16,
  parameter int OP_W         = 4,
  parameter int RIDX_W       = 4,
  parameter int DRAIN_STAGES = 3
) (
  input logic             clk,
  input logic             rst,
  pipe_ctrl_unit_if.slave bus
);

  localparam int CNT_W = (DRAIN_STAGES > 32'sd0) ? $clog2(DRAIN_STAGES + 32'sd1) : 32'sd1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DRAIN_STAGES);

  logic [OP_W-1:0]   opcode_s;
  logic [RIDX_W-1:0] rd_s, rs_s, rt_s;
  ctrl_t             dec_ctrl_s;
  logic              uses_rs_s, uses_rt_s, uses_rd_src_s;
  logic              flush_s, hlt_s, stall_s, pc_write_s, if_id_write_s;

  halt_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  ctrl_t             ex_ctrl_q, ex_ctrl_d;
  logic              ex_valid_q, ex_valid_d;
  logic [RIDX_W-1:0] ex_rd_q, ex_rd_d;
  logic              halted_q, halted_d;

  assign opcode_s = bus.id_instr[INSTR_W-1 -: OP_W];
  assign rd_s     = bus.id_instr[2*RIDX_W +: RIDX_W];
  assign rs_s     = bus.id_instr[RIDX_W +: RIDX_W];
  assign rt_s     = bus.id_instr[0 +: RIDX_W];

  ctrl_decode #(.OP_W(OP_W)) u_decode (
    .opcode      (opcode_s),
    .ctrl        (dec_ctrl_s),
    .uses_rs     (uses_rs_s),
    .uses_rt     (uses_rt_s),
    .uses_rd_src (uses_rd_src_s)
  );

  // Branches cannot resolve behind a draining HLT, so flush only matters in RUN.
  assign flush_s = bus.ex_branch_taken && (state_q == ST_RUN);
  assign hlt_s   = bus.id_valid && (opcode_s == OP_HLT) && !flush_s;
  assign stall_s = ex_valid_q && ex_ctrl_q.mem_read && bus.id_valid &&
                   (reg_hit(ex_rd_q, rs_s, uses_rs_s) ||
                    reg_hit(ex_rd_q, rt_s, uses_rt_s) ||
                    reg_hit(ex_rd_q, rd_s, uses_rd_src_s));

  // next-state, hazard enables and ID/EX slice contents
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    halted_d      = halted_q;
    ex_valid_d    = 1'b0;
    ex_ctrl_d     = CTRL_BUBBLE;
    ex_rd_d       = '0;
    pc_write_s    = 1'b1;
    if_id_write_s = 1'b1;
    case (state_q)
      ST_RUN: begin
        if (flush_s) begin
          ex_valid_d = 1'b0;
        end else if (hlt_s) begin
          pc_write_s    = 1'b0;
          if_id_write_s = 1'b0;
          if (DRAIN_STAGES == 32'sd0) begin
            state_d  = ST_HALTED;
            halted_d = 1'b1;
          end else begin
            state_d = ST_DRAIN;
            cnt_d   = CNT_INIT;
          end
        end else if (stall_s) begin
          pc_write_s    = 1'b0;
          if_id_write_s = 1'b0;
        end else if (bus.id_valid) begin
          ex_valid_d = 1'b1;
          ex_ctrl_d  = dec_ctrl_s;
          ex_rd_d    = rd_s;
        end else begin
          ex_valid_d = 1'b0;
        end
      end
      ST_DRAIN: begin
        pc_write_s    = 1'b0;
        if_id_write_s = 1'b0;
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d    = '0;
          state_d  = ST_HALTED;
          halted_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_HALTED: begin
        pc_write_s    = 1'b0;
        if_id_write_s = 1'b0;
        halted_d      = 1'b1;
      end
      default: begin
        state_d  = ST_RUN;
        cnt_d    = '0;
        halted_d = 1'b0;
      end
    endcase
  end

  // FSM state, drain counter and ID/EX control slice
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      cnt_q      <= '0;
      halted_q   <= 1'b0;
      ex_valid_q <= 1'b0;
      ex_ctrl_q  <= CTRL_BUBBLE;
      ex_rd_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      halted_q   <= halted_d;
      ex_valid_q <= ex_valid_d;
      ex_ctrl_q  <= ex_ctrl_d;
      ex_rd_q    <= ex_rd_d;
    end
  end

  assign bus.pc_write      = pc_write_s;
  assign bus.if_id_write   = if_id_write_s;
  assign bus.if_id_flush   = flush_s;
  assign bus.ex_valid      = ex_valid_q;
  assign bus.ex_reg_write  = ex_ctrl_q.reg_write;
  assign bus.ex_mem_read   = ex_ctrl_q.mem_read;
  assign bus.ex_mem_write  = ex_ctrl_q.mem_write;
  assign bus.ex_alu_src    = ex_ctrl_q.alu_src;
  assign bus.ex_lhb        = ex_ctrl_q.lhb;
  assign bus.ex_alu_op     = ex_ctrl_q.alu_op;
  assign bus.ex_mem_to_reg = ex_ctrl_q.mem_to_reg;
  assign bus.ex_pc_src     = ex_ctrl_q.pc_src;
  assign bus.ex_flag_we    = ex_ctrl_q.flag_we;
  assign bus.ex_rd         = ex_rd_q;
  assign bus.halted        = halted_q;

endmodule
